// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the main control unit and the iterative
// multiply/divide units. Captures MULT/DIV/MTHI/MTLO requests, runs the
// selected unit with a start level, bounds its run time, commits results
// into the architectural HI/LO registers and reports busy/done/exceptions.
// All outputs are registered.
//
// Optional build macro: MULDIV_LATENCY_STAT_EN adds w_LastLatency[7:0], the
// number of cycles from request capture to DRAIN entry of the last MULT/DIV.
module muldiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        w_OpReq,
  input  logic [1:0]  w_OpSel,
  input  logic [31:0] w_RsData,
  input  logic [31:0] w_RtData,
  output logic [31:0] w_OpA,
  output logic [31:0] w_OpB,
  output logic        w_MultStart,
  input  logic        w_MultStop,
  input  logic [31:0] w_MULTHI,
  input  logic [31:0] w_MULTLO,
  output logic        w_DivStart,
  input  logic        w_DivStop,
  input  logic [31:0] w_DIVHI,
  input  logic [31:0] w_DIVLO,
  output logic        w_MulDivRst,
  output logic [31:0] w_HI,
  output logic [31:0] w_LO,
  output logic        w_Busy,
  output logic        w_Done,
  output logic        w_DivZeroExc,
  output logic        w_Timeout
`ifdef MULDIV_LATENCY_STAT_EN
  ,
  output logic [7:0]  w_LastLatency
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MULT_RUN = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DRAIN    = 2'd3
  } state_e;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  // Last run-state count value before the operation is aborted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       opa_q, opa_d;
  logic [31:0]       opb_q, opb_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              mstart_q, mstart_d;
  logic              dstart_q, dstart_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  logic              to_q, to_d;
  logic              mdrst_q, mdrst_d;

  // Stop and results of whichever unit is currently running; the other
  // unit's stop is ignored so a stale pulse cannot end the wrong operation.
  logic              sel_stop;
  logic [31:0]       sel_hi;
  logic [31:0]       sel_lo;

`ifdef MULDIV_LATENCY_STAT_EN
  logic [7:0]        lat_run_q, lat_run_d;
  logic [7:0]        lat_q, lat_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign sel_stop = (state_q == S_MULT_RUN) ? w_MultStop : w_DivStop;
  assign sel_hi   = (state_q == S_MULT_RUN) ? w_MULTHI   : w_DIVHI;
  assign sel_lo   = (state_q == S_MULT_RUN) ? w_MULTLO   : w_DIVLO;

  // State and output registers; async reset aborts any operation in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mstart_q <= 1'b0;
      dstart_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      to_q     <= 1'b0;
      mdrst_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mstart_q <= mstart_d;
      dstart_q <= dstart_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      to_q     <= to_d;
      mdrst_q  <= mdrst_d;
    end
  end

`ifdef MULDIV_LATENCY_STAT_EN
  // Latency statistic registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      lat_run_q <= '0;
      lat_q     <= '0;
    end else begin
      lat_run_q <= lat_run_d;
      lat_q     <= lat_d;
    end
  end
`endif

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mstart_d = mstart_q;
    dstart_d = dstart_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    to_d     = 1'b0;
    mdrst_d  = 1'b0;
`ifdef MULDIV_LATENCY_STAT_EN
    lat_run_d = lat_run_q;
    lat_d     = lat_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (w_OpReq) begin
          unique case (w_OpSel)
            OP_MTHI: begin
              hi_d   = w_RsData;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = w_RsData;
              done_d = 1'b1;
            end
            OP_MULT: begin
              opa_d    = w_RsData;
              opb_d    = w_RtData;
              mstart_d = 1'b1;
              busy_d   = 1'b1;
              cnt_d    = '0;
              state_d  = S_MULT_RUN;
`ifdef MULDIV_LATENCY_STAT_EN
              lat_run_d = 8'd1;
`endif
            end
            OP_DIV: begin
              if (w_RtData != 32'd0) begin
                opa_d    = w_RsData;
                opb_d    = w_RtData;
                dstart_d = 1'b1;
                busy_d   = 1'b1;
                cnt_d    = '0;
                state_d  = S_DIV_RUN;
`ifdef MULDIV_LATENCY_STAT_EN
                lat_run_d = 8'd1;
`endif
              end else begin
                // Zero divisor: never start the divider, report straight away.
                busy_d  = 1'b1;
                done_d  = 1'b1;
                dz_d    = 1'b1;
                mdrst_d = 1'b1;
                state_d = S_DRAIN;
`ifdef MULDIV_LATENCY_STAT_EN
                lat_d = 8'd1;
`endif
              end
            end
            default: ;
          endcase
        end
      end

      S_MULT_RUN, S_DIV_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef MULDIV_LATENCY_STAT_EN
        lat_run_d = sat_inc8(lat_run_q);
`endif
        // Stop is checked first so a result arriving on the last allowed
        // cycle is still committed rather than reported as a timeout.
        if (sel_stop) begin
          hi_d     = sel_hi;
          lo_d     = sel_lo;
          mstart_d = 1'b0;
          dstart_d = 1'b0;
          done_d   = 1'b1;
          mdrst_d  = 1'b1;
          state_d  = S_DRAIN;
`ifdef MULDIV_LATENCY_STAT_EN
          lat_d = lat_run_q;
`endif
        end else if (cnt_q == CNT_LAST) begin
          mstart_d = 1'b0;
          dstart_d = 1'b0;
          to_d     = 1'b1;
          done_d   = 1'b1;
          mdrst_d  = 1'b1;
          state_d  = S_DRAIN;
`ifdef MULDIV_LATENCY_STAT_EN
          lat_d = lat_run_q;
`endif
        end
      end

      S_DRAIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign w_OpA        = opa_q;
  assign w_OpB        = opb_q;
  assign w_MultStart  = mstart_q;
  assign w_DivStart   = dstart_q;
  assign w_MulDivRst  = mdrst_q;
  assign w_HI         = hi_q;
  assign w_LO         = lo_q;
  assign w_Busy       = busy_q;
  assign w_Done       = done_q;
  assign w_DivZeroExc = dz_q;
  assign w_Timeout    = to_q;
`ifdef MULDIV_LATENCY_STAT_EN
  assign w_LastLatency = lat_q;
`endif

endmodule
